gpu_command_decoder: RTL and testbench



---
 rtl/gpu_command_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_gpu_command_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_command_decoder.sv
// Parses host command bytes into GPU engine requests and returns one response byte per command.
// Optional inter-byte timeout in the argument phase is enabled by defining CMD_TIMEOUT_EN.
module gpu_command_decoder #(
   parameter int WIDTH          = 320,
   parameter int HEIGHT         = 200,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [8:0] X1,
   output logic [7:0] Y1,
   output logic [8:0] X2,
   output logic [7:0] Y2,
   output logic [8:0] op_x_width,
   output logic [7:0] op_y_height,
   output logic       fill_value,
   output logic [7:0] write_ram_byte,
   output logic       start_fill,
   output logic       start_blit,
   output logic       start_ram_read,
   output logic       start_ram_write,
   input  logic       gpu_busy,
   input  logic       gpu_error,
   input  logic [7:0] gpu_ram_byte,
   input  logic       gpu_ram_byte_ready
);
   typedef enum logic [2:0] {S_IDLE, S_ARGS, S_ISSUE, S_WAIT_DONE, S_RESP} state_t;
   typedef enum logic [1:0] {OP_FILL, OP_BLIT, OP_READ, OP_WRITE} op_t;

   localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
   localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t     state_q, state_d;
   op_t        op_q, op_d;
   logic [3:0] arg_idx_q, arg_idx_d;
   logic [3:0] last_q, last_d;
   logic [8:0] x1_q, x1_d, x2_q, x2_d, w_q, w_d;
   logic [7:0] y1_q, y1_d, y2_q, y2_d, h_q, h_d;
   logic       fv_q, fv_d;
   logic [7:0] wrb_q, wrb_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       accept;
   logic       range_err;
`ifdef CMD_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] to_cnt_q, to_cnt_d;
`endif

   // Gated by rst_n so every output reads 0 while reset is held.
   assign rx_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_ARGS));
   assign accept   = rx_valid && rx_ready;

   // Engine reports coordinate errors itself; this pre-check guarantees the 0x01 response either way.
   assign range_err = ({1'b0, x1_q} > WIDTH_L) || ({1'b0, y1_q} > HEIGHT_L) ||
                      ((op_q == OP_BLIT) && (({1'b0, x2_q} > WIDTH_L) || ({1'b0, y2_q} > HEIGHT_L)));

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      arg_idx_d = arg_idx_q;
      last_d    = last_q;
      x1_d      = x1_q;
      y1_d      = y1_q;
      x2_d      = x2_q;
      y2_d      = y2_q;
      w_d       = w_q;
      h_d       = h_q;
      fv_d      = fv_q;
      wrb_d     = wrb_q;
      tx_data_d = tx_data_q;
`ifdef CMD_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            arg_idx_d = 4'd0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_d  = 32'd0;
`endif
            if (accept) begin
               state_d = S_ARGS;
               case (rx_data)
                  8'h01: begin op_d = OP_FILL;  last_d = 4'd6; end
                  8'h02: begin op_d = OP_BLIT;  last_d = 4'd8; end
                  8'h03: begin op_d = OP_READ;  last_d = 4'd2; end
                  8'h04: begin op_d = OP_WRITE; last_d = 4'd3; end
                  default: begin
                     tx_data_d = 8'hFF;
                     state_d   = S_RESP;
                  end
               endcase
            end
         end
         S_ARGS: begin
            if (accept) begin
               arg_idx_d = arg_idx_q + 4'd1;
`ifdef CMD_TIMEOUT_EN
               to_cnt_d  = 32'd0;
`endif
               case (arg_idx_q)
                  4'd0: x1_d[7:0] = rx_data;
                  4'd1: x1_d[8]   = rx_data[0];
                  4'd2: y1_d      = rx_data;
                  default: begin
                     case (op_q)
                        OP_FILL: begin
                           case (arg_idx_q)
                              4'd3:    w_d[7:0] = rx_data;
                              4'd4:    w_d[8]   = rx_data[0];
                              4'd5:    h_d      = rx_data;
                              default: fv_d     = rx_data[0];
                           endcase
                        end
                        OP_BLIT: begin
                           case (arg_idx_q)
                              4'd3:    x2_d[7:0] = rx_data;
                              4'd4:    x2_d[8]   = rx_data[0];
                              4'd5:    y2_d      = rx_data;
                              4'd6:    w_d[7:0]  = rx_data;
                              4'd7:    w_d[8]    = rx_data[0];
                              default: h_d       = rx_data;
                           endcase
                        end
                        OP_WRITE: wrb_d = rx_data;
                        default: ;
                     endcase
                  end
               endcase
               if (arg_idx_q == last_q) state_d = S_ISSUE;
            end
`ifdef CMD_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               tx_data_d = 8'hFE;
               state_d   = S_RESP;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
`endif
         end
         S_ISSUE: state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (op_q == OP_READ) begin
               if (gpu_ram_byte_ready) begin
                  tx_data_d = gpu_ram_byte;
                  state_d   = S_RESP;
               end
            end else if (!gpu_busy) begin
               tx_data_d = (op_q == OP_WRITE) ? 8'h00 : {7'b0, gpu_error | range_err};
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (tx_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_FILL;
         arg_idx_q <= 4'd0;
         last_q    <= 4'd0;
         x1_q      <= 9'd0;
         y1_q      <= 8'd0;
         x2_q      <= 9'd0;
         y2_q      <= 8'd0;
         w_q       <= 9'd0;
         h_q       <= 8'd0;
         fv_q      <= 1'b0;
         wrb_q     <= 8'd0;
         tx_data_q <= 8'd0;
`ifdef CMD_TIMEOUT_EN
         to_cnt_q  <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         arg_idx_q <= arg_idx_d;
         last_q    <= last_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         w_q       <= w_d;
         h_q       <= h_d;
         fv_q      <= fv_d;
         wrb_q     <= wrb_d;
         tx_data_q <= tx_data_d;
`ifdef CMD_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end
   end

   // Starts decode straight from state so reset removes them without waiting for a clock.
   assign start_fill      = (state_q == S_ISSUE) && (op_q == OP_FILL);
   assign start_blit      = (state_q == S_ISSUE) && (op_q == OP_BLIT);
   assign start_ram_read  = (state_q == S_ISSUE) && (op_q == OP_READ);
   assign start_ram_write = (state_q == S_ISSUE) && (op_q == OP_WRITE);

   assign tx_valid       = (state_q == S_RESP);
   assign tx_data        = tx_data_q;
   assign X1             = x1_q;
   assign Y1             = y1_q;
   assign X2             = x2_q;
   assign Y2             = y2_q;
   assign op_x_width     = w_q;
   assign op_y_height    = h_q;
   assign fill_value     = fv_q;
   assign write_ram_byte = wrb_q;
endmodule

// File: tb/tb_gpu_command_decoder.sv
// Randomized self-checking bench for gpu_command_decoder with a simple engine model.
module tb_gpu_command_decoder;
   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [8:0] X1, X2, op_x_width;
   logic [7:0] Y1, Y2, op_y_height, write_ram_byte;
   logic       fill_value;
   logic       start_fill, start_blit, start_ram_read, start_ram_write;
   logic       gpu_busy, gpu_error, gpu_ram_byte_ready;
   logic [7:0] gpu_ram_byte;

   always #5 clk = ~clk;

   gpu_command_decoder #(.WIDTH(320), .HEIGHT(200), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2),
      .op_x_width(op_x_width), .op_y_height(op_y_height),
      .fill_value(fill_value), .write_ram_byte(write_ram_byte),
      .start_fill(start_fill), .start_blit(start_blit),
      .start_ram_read(start_ram_read), .start_ram_write(start_ram_write),
      .gpu_busy(gpu_busy), .gpu_error(gpu_error),
      .gpu_ram_byte(gpu_ram_byte), .gpu_ram_byte_ready(gpu_ram_byte_ready)
   );

   // Engine model: busy for lat_cfg cycles after a start, read result strobed after lat_cfg cycles.
   int         lat_cfg = 1;
   logic       err_cfg = 1'b0;
   logic [7:0] ram_cfg = 8'h00;
   int         busy_cnt, rd_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= 0;
         rd_cnt   <= 0;
      end else begin
         if (start_fill || start_blit || start_ram_write) busy_cnt <= lat_cfg;
         else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
         if (start_ram_read) rd_cnt <= lat_cfg;
         else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
      end
   end
   assign gpu_busy           = (busy_cnt != 0);
   assign gpu_error          = err_cfg;
   assign gpu_ram_byte_ready = (rd_cnt == 1);
   assign gpu_ram_byte       = (rd_cnt == 1) ? ram_cfg : 8'h00;

   // Monitors: running counts only, read as deltas by the stimulus.
   int n_sf = 0, n_sb = 0, n_sr = 0, n_sw = 0, n_acc = 0, n_busy_start = 0;
   always @(posedge clk) begin
      if (start_fill)      n_sf <= n_sf + 1;
      if (start_blit)      n_sb <= n_sb + 1;
      if (start_ram_read)  n_sr <= n_sr + 1;
      if (start_ram_write) n_sw <= n_sw + 1;
      if (rx_valid && rx_ready) n_acc <= n_acc + 1;
      if ((start_fill || start_blit || start_ram_read || start_ram_write) && gpu_busy)
         n_busy_start <= n_busy_start + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      int g;
      int t;
      g = $urandom_range(0, 2);
      t = 0;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (g) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
   endtask

   function automatic int op_kind(input logic [7:0] op);
      if (op >= 8'h01 && op <= 8'h04) return int'(op);
      return 0;
   endfunction

   task automatic run_cmd(input string name, input logic [7:0] b[10], input int stall);
      int         kind, nb, t, acc0, sf0, sb0, sr0, sw0;
      logic [8:0] ex1, ex2, ew;
      logic [7:0] ey1, ey2, eh, ed, eresp;
      logic       efv;
      logic [3:0] exp_start;
      logic [7:0] v;
      kind = op_kind(b[0]);
      // Reference: fields from little-endian arguments, response from the command rules.
      v = b[2]; ex1 = {v[0], b[1]}; ey1 = b[3];
      ex2 = 9'd0; ey2 = 8'd0; ew = 9'd0; eh = 8'd0; efv = 1'b0; ed = b[4];
      case (kind)
         1: begin v = b[5]; ew = {v[0], b[4]}; eh = b[6]; v = b[7]; efv = v[0]; nb = 8; end
         2: begin v = b[5]; ex2 = {v[0], b[4]}; ey2 = b[6]; v = b[8]; ew = {v[0], b[7]}; eh = b[9]; nb = 10; end
         3: nb = 4;
         4: nb = 5;
         default: nb = 1;
      endcase
      case (kind)
         1: eresp = {7'b0, err_cfg || ex1 > 320 || ey1 > 200};
         2: eresp = {7'b0, err_cfg || ex1 > 320 || ey1 > 200 || ex2 > 320 || ey2 > 200};
         3: eresp = ram_cfg;
         4: eresp = 8'h00;
         default: eresp = 8'hFF;
      endcase
      exp_start = (kind == 0) ? 4'b0000 : 4'(1 << (kind - 1));
      acc0 = n_acc; sf0 = n_sf; sb0 = n_sb; sr0 = n_sr; sw0 = n_sw;

      for (int i = 0; i < nb; i++) send_byte(b[i]);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      check_eq({name, "_start_at_issue"},
               32'({start_ram_write, start_ram_read, start_blit, start_fill}), 32'(exp_start));
      if (kind != 0) begin
         check_eq({name, "_X1"}, 32'(X1), 32'(ex1));
         check_eq({name, "_Y1"}, 32'(Y1), 32'(ey1));
      end
      if (kind == 1 || kind == 2) begin
         check_eq({name, "_W"}, 32'(op_x_width), 32'(ew));
         check_eq({name, "_H"}, 32'(op_y_height), 32'(eh));
      end
      if (kind == 1) check_eq({name, "_fill_value"}, 32'(fill_value), 32'(efv));
      if (kind == 2) begin
         check_eq({name, "_X2"}, 32'(X2), 32'(ex2));
         check_eq({name, "_Y2"}, 32'(Y2), 32'(ey2));
      end
      if (kind == 4) check_eq({name, "_wr_byte"}, 32'(write_ram_byte), 32'(ed));

      t = 0;
      while (!tx_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check_eq({name, "_tx_valid_wait"}, 32'(tx_valid), 32'd1);
      check_eq({name, "_resp"}, 32'(tx_data), 32'(eresp));
      repeat (stall) @(negedge clk);
      check_eq({name, "_resp_held"}, 32'({tx_valid, tx_data}), 32'({1'b1, eresp}));
      if (kind != 0) check_eq({name, "_X1_stable"}, 32'(X1), 32'(ex1));
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check_eq({name, "_tx_drop"}, 32'(tx_valid), 32'd0);
      check_eq({name, "_bytes_taken"}, 32'(n_acc - acc0), 32'(nb));
      check_eq({name, "_start_count"},
               32'({4'(n_sw - sw0), 4'(n_sr - sr0), 4'(n_sb - sb0), 4'(n_sf - sf0)}),
               32'({3'b0, exp_start[3], 3'b0, exp_start[2], 3'b0, exp_start[1], 3'b0, exp_start[0]}));
      $display("cmd %s op=%02h resp=%02h exp=%02h", name, b[0], tx_data, eresp);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] c[10];
      int acc0, st0;
      #1;
      check_eq("reset_outputs",
               32'({rx_ready, tx_valid, start_fill, start_blit, start_ram_read, start_ram_write}), 32'd0);
      check_eq("reset_fields", 32'({X1, Y1, write_ram_byte, fill_value}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      lat_cfg = 5; err_cfg = 1'b0;
      c = '{8'h01, 8'h0A, 8'h00, 8'h14, 8'h10, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00};
      run_cmd("fill", c, 1);
      lat_cfg = 3;
      c = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01, 8'h32, 8'h08, 8'h00, 8'h08};
      run_cmd("blit", c, 0);
      lat_cfg = 2; err_cfg = 1'b1;
      c = '{8'h01, 8'hFF, 8'h01, 8'h10, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
      run_cmd("fill_oob", c, 0);
      err_cfg = 1'b0; ram_cfg = 8'hA5; lat_cfg = 4;
      c = '{8'h03, 8'h05, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_cmd("read", c, 3);
      c = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_cmd("unknown", c, 1);
      c = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_cmd("write", c, 0);

      // Reset in the middle of a FILL: nothing issued, parser back in IDLE.
      st0 = n_sf + n_sb + n_sr + n_sw;
      send_byte(8'h01); send_byte(8'h0A); send_byte(8'h00);
      @(negedge clk);
      rx_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("midreset_outputs", 32'({rx_ready, tx_valid, X1}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("midreset_no_start", 32'(n_sf + n_sb + n_sr + n_sw - st0), 32'd0);
      lat_cfg = 1;
      c = '{8'h04, 8'h21, 8'h01, 8'hC8, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_cmd("write_after_reset", c, 0);

`ifdef CMD_TIMEOUT_EN
      begin : timeout_test
         int w;
         st0  = n_sf + n_sb + n_sr + n_sw;
         acc0 = n_acc;
         send_byte(8'h01); send_byte(8'h0A); send_byte(8'h00);
         @(negedge clk);
         rx_valid = 1'b0;
         w = 0;
         while (!tx_valid && w < TO + 50) begin
            @(negedge clk);
            w++;
         end
         check_eq("timeout_resp_valid", 32'(tx_valid), 32'd1);
         check_eq("timeout_resp", 32'(tx_data), 32'hFE);
         check_eq("timeout_window", 32'(w >= TO - 3 && w <= TO + 3), 32'd1);
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
         check_eq("timeout_no_start", 32'(n_sf + n_sb + n_sr + n_sw - st0), 32'd0);
         check_eq("timeout_bytes", 32'(n_acc - acc0), 32'd3);
         $display("cmd timeout resp=%02h after %0d cycles", tx_data, w);
      end
`endif

      // Randomized commands against the reference model.
      for (int k = 0; k < 40; k++) begin
         int kind;
         kind = $urandom_range(0, 4);
         for (int j = 1; j < 10; j++) c[j] = 8'($urandom);
         if ($urandom_range(0, 1) == 1) c[3] = 8'($urandom_range(0, 200));
         c[0] = (kind == 0) ? 8'($urandom_range(5, 255)) : 8'(kind);
         lat_cfg = $urandom_range(1, 6);
         err_cfg = 1'($urandom_range(0, 1));
         ram_cfg = 8'($urandom);
         run_cmd($sformatf("rand%0d", k), c, $urandom_range(0, 3));
      end

      check_eq("start_while_busy", 32'(n_busy_start), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
